pe_ws_dbuf: RTL and testbench
=============================

// Module: pe_ws_dbuf
// PURPOSE
// - Next-gen weight-stationary systolic PE: signed MAC, double-buffered weights, valid tracking.
// - Shadow weight loads through the column chain while the active weight computes; a swap pulse
//   commits it with zero bubbles. Tiles into an N x N MXU: DIN/valid flow down, PSUM flows right.
// PARAMETERS
// - DATA_IN_BW      8   signed activation width
// - WEIGHT_BW       8   signed weight width
// - PARTIAL_SUM_BW  19  signed psum width; must be >= DATA_IN_BW+WEIGHT_BW (elab check)
// PORTS
// - clk        in   1               single clock, rising edge
// - rstn       in   1               synchronous reset, active-low
// - DIN        in   DATA_IN_BW      signed activation
// - din_vld    in   1               DIN valid
// - PSUM_IN    in   PARTIAL_SUM_BW  signed psum from left neighbour
// - W_IN       in   WEIGHT_BW       weight from PE above (load chain)
// - w_ld_in    in   1               W_IN valid: capture into shadow
// - w_swap_in  in   1               commit shadow -> active (pulse)
// - DF_COL     out  DATA_IN_BW      registered DIN to PE below
// - dout_vld   out  1               registered din_vld to PE below; also PSUM_OUT valid
// - PSUM_OUT   out  PARTIAL_SUM_BW  registered psum to right neighbour
// - W_OUT      out  WEIGHT_BW       registered W_IN to PE below
// - w_ld_out   out  1               registered w_ld_in
// - w_swap_out out  1               registered w_swap_in (row-by-row swap wavefront)
// - w_err      out  1               sticky: swap requested with empty shadow
// - ovf        out  1               sticky psum overflow (PE_SAT_EN only; else tied 0)
// BEHAVIOUR
// - Reset (rstn=0 at edge): all outputs 0, active/shadow weights 0, FSM=EMPTY. Mid-op reset wins
//   over every other event that cycle; in-flight data/weights discarded.
// - Latency: every output registered, 1 cycle. PSUM_OUT(t+1)=PSUM_IN(t)+DIN(t)*W_act(t).
// - Arithmetic: wx = signed DIN*W_act, full DATA_IN_BW+WEIGHT_BW bits, sign-extend; sum at
//   PARTIAL_SUM_BW+1 bits, truncated to PARTIAL_SUM_BW (wrap) unless PE_SAT_EN.
// - din_vld=0: PSUM_OUT <= PSUM_IN (passthrough, no product); DF_COL still registered.
// - W_act used is the value before this cycle's swap (swap effective next cycle).
// - Weight FSM (sh_full flag + act_vld flag), states:
//   EMPTY  (no active, no shadow): ld->SHADOW; swap->EMPTY, w_err<=1.
//   SHADOW (shadow only): ld->SHADOW (overwrite); swap->ACTIVE; ld&swap->BOTH (old->act,new->sh).
//   ACTIVE (active only): ld->BOTH; swap->ACTIVE, active kept, w_err<=1; ld&swap->BOTH? no:
//     ld&swap with empty shadow -> w_err<=1, new W_IN to shadow, state BOTH.
//   BOTH   (active+shadow): ld->BOTH (shadow overwritten); swap->ACTIVE; ld&swap->BOTH.
// - No active weight (EMPTY/SHADOW): product forced 0 even if din_vld=1.
// - Chain: W_OUT/w_ld_out/w_swap_out forwarded unconditionally every cycle regardless of state.
// - w_err, ovf clear only on reset.
// CONFIGURATION
// - PE_SAT_EN defined: sum clamped to [-2^(PARTIAL_SUM_BW-1), 2^(PARTIAL_SUM_BW-1)-1];
//   any clamp on a valid cycle sets ovf (sticky).
// - PE_SAT_EN undefined: two's-complement wrap, ovf constant 0, no clamp logic synthesised.
// TESTING
// - Reset: rstn=0 two cycles with random inputs -> all outputs 0, state EMPTY; DIN=5,vld,W none
//   -> PSUM_OUT=PSUM_IN.
// - Load/swap: W_IN=3 ld; swap; DIN=-4 vld, PSUM_IN=10 -> PSUM_OUT=-2 next cycle, dout_vld=1.
// - Double buffer: active=3, ld W_IN=-7 while streaming DIN=2 -> PSUM uses 3 until swap cycle+1,
//   then -7; no bubble on dout_vld.
// - Errors: swap in EMPTY -> w_err=1, PSUM_OUT=PSUM_IN; ld&swap in SHADOW(sh=2,W_IN=9)->act=2,sh=9.
// - Extremes: DIN=-128, W=-128, PSUM_IN=2^18-1 -> wrap to -2^18+16383 w/o macro; with PE_SAT_EN
//   PSUM_OUT=2^18-1 and ovf=1.
// - Chain/reset mid-op: w_swap_in pulse -> w_swap_out one cycle later; rstn=0 during ld -> shadow 0.

Source files
------------

// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE: signed MAC, double-buffered weight, valid/weight chain forwarding.
// Optional macro PE_SAT_EN: clamp the partial sum and raise sticky ovf instead of wrapping.
module pe_ws_dbuf #(
  parameter int DATA_IN_BW     = 8,
  parameter int WEIGHT_BW      = 8,
  parameter int PARTIAL_SUM_BW = 19
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic signed [DATA_IN_BW-1:0]     DIN,
  input  logic                             din_vld,
  input  logic signed [PARTIAL_SUM_BW-1:0] PSUM_IN,
  input  logic signed [WEIGHT_BW-1:0]      W_IN,
  input  logic                             w_ld_in,
  input  logic                             w_swap_in,
  output logic signed [DATA_IN_BW-1:0]     DF_COL,
  output logic                             dout_vld,
  output logic signed [PARTIAL_SUM_BW-1:0] PSUM_OUT,
  output logic signed [WEIGHT_BW-1:0]      W_OUT,
  output logic                             w_ld_out,
  output logic                             w_swap_out,
  output logic                             w_err,
  output logic                             ovf
);

  localparam int PROD_BW = DATA_IN_BW + WEIGHT_BW;

  generate
    if (PARTIAL_SUM_BW < PROD_BW) begin : g_bad_psum_bw
      $error("pe_ws_dbuf: PARTIAL_SUM_BW must be >= DATA_IN_BW+WEIGHT_BW");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_EMPTY  = 2'b00,
    ST_SHADOW = 2'b01,
    ST_ACTIVE = 2'b10,
    ST_BOTH   = 2'b11
  } wstate_e;

  wstate_e                            state_q, state_d;
  logic signed [WEIGHT_BW-1:0]        w_act_q, w_act_d;
  logic signed [WEIGHT_BW-1:0]        w_sh_q, w_sh_d;
  logic                               w_err_q, w_err_d;
  logic signed [DATA_IN_BW-1:0]       df_col_q, df_col_d;
  logic                               dout_vld_q, dout_vld_d;
  logic signed [PARTIAL_SUM_BW-1:0]   psum_q, psum_d;
  logic signed [WEIGHT_BW-1:0]        w_out_q, w_out_d;
  logic                               w_ld_q, w_ld_d;
  logic                               w_swap_q, w_swap_d;
  logic                               act_vld_s;
  logic signed [PROD_BW-1:0]          prod_s;

`ifdef PE_SAT_EN
  localparam logic [PARTIAL_SUM_BW-1:0] PS_MAX = {1'b0, {(PARTIAL_SUM_BW-1){1'b1}}};
  localparam logic [PARTIAL_SUM_BW-1:0] PS_MIN = {1'b1, {(PARTIAL_SUM_BW-1){1'b0}}};

  logic                               ovf_q, ovf_d;
  logic                               clamp_s;
  logic signed [PARTIAL_SUM_BW:0]     sum_s;

  // Top two bits disagree exactly when the widened sum left the psum range.
  function automatic logic [PARTIAL_SUM_BW-1:0] sat_psum(input logic [PARTIAL_SUM_BW:0] s);
    logic [PARTIAL_SUM_BW-1:0] r;
    if (s[PARTIAL_SUM_BW] != s[PARTIAL_SUM_BW-1]) begin
      r = s[PARTIAL_SUM_BW] ? PS_MIN : PS_MAX;
    end else begin
      r = s[PARTIAL_SUM_BW-1:0];
    end
    return r;
  endfunction
`endif

  // Next-state logic: MAC datapath, output forwarding and weight buffer FSM.
  always_comb begin
    state_d    = state_q;
    w_act_d    = w_act_q;
    w_sh_d     = w_sh_q;
    w_err_d    = w_err_q;
    df_col_d   = DIN;
    dout_vld_d = din_vld;
    w_out_d    = W_IN;
    w_ld_d     = w_ld_in;
    w_swap_d   = w_swap_in;

    act_vld_s = (state_q == ST_ACTIVE) || (state_q == ST_BOTH);
    if (din_vld && act_vld_s) begin
      prod_s = PROD_BW'(DIN) * PROD_BW'(w_act_q);
    end else begin
      prod_s = '0;
    end

`ifdef PE_SAT_EN
    sum_s   = (PARTIAL_SUM_BW+1)'(PSUM_IN) + (PARTIAL_SUM_BW+1)'(prod_s);
    clamp_s = (sum_s[PARTIAL_SUM_BW] != sum_s[PARTIAL_SUM_BW-1]);
    psum_d  = sat_psum(sum_s);
    ovf_d   = ovf_q | (clamp_s & din_vld);
`else
    psum_d  = PSUM_IN + PARTIAL_SUM_BW'(prod_s);
`endif

    // A swap always consumes the old shadow before this cycle's load refills it.
    case (state_q)
      ST_EMPTY: begin
        if (w_swap_in) begin
          w_err_d = 1'b1;
        end else begin
          w_err_d = w_err_q;
        end
        state_d = w_ld_in ? ST_SHADOW : ST_EMPTY;
      end
      ST_SHADOW: begin
        if (w_swap_in) begin
          w_act_d = w_sh_q;
          state_d = w_ld_in ? ST_BOTH : ST_ACTIVE;
        end else begin
          state_d = ST_SHADOW;
        end
      end
      ST_ACTIVE: begin
        if (w_swap_in) begin
          w_err_d = 1'b1;
        end else begin
          w_err_d = w_err_q;
        end
        state_d = w_ld_in ? ST_BOTH : ST_ACTIVE;
      end
      ST_BOTH: begin
        if (w_swap_in) begin
          w_act_d = w_sh_q;
          state_d = w_ld_in ? ST_BOTH : ST_ACTIVE;
        end else begin
          state_d = ST_BOTH;
        end
      end
      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    if (w_ld_in) begin
      w_sh_d = W_IN;
    end else begin
      w_sh_d = w_sh_q;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= ST_EMPTY;
      w_act_q    <= '0;
      w_sh_q     <= '0;
      w_err_q    <= 1'b0;
      df_col_q   <= '0;
      dout_vld_q <= 1'b0;
      psum_q     <= '0;
      w_out_q    <= '0;
      w_ld_q     <= 1'b0;
      w_swap_q   <= 1'b0;
`ifdef PE_SAT_EN
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      w_act_q    <= w_act_d;
      w_sh_q     <= w_sh_d;
      w_err_q    <= w_err_d;
      df_col_q   <= df_col_d;
      dout_vld_q <= dout_vld_d;
      psum_q     <= psum_d;
      w_out_q    <= w_out_d;
      w_ld_q     <= w_ld_d;
      w_swap_q   <= w_swap_d;
`ifdef PE_SAT_EN
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign DF_COL     = df_col_q;
  assign dout_vld   = dout_vld_q;
  assign PSUM_OUT   = psum_q;
  assign W_OUT      = w_out_q;
  assign w_ld_out   = w_ld_q;
  assign w_swap_out = w_swap_q;
  assign w_err      = w_err_q;
`ifdef PE_SAT_EN
  assign ovf        = ovf_q;
`else
  assign ovf        = 1'b0;
`endif

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Scoreboard bench for pe_ws_dbuf: directed spec scenarios then randomized traffic vs a flag/int model.
module tb_pe_ws_dbuf;
  localparam int DBW = 8;
  localparam int WBW = 8;
  localparam int PBW = 19;
  localparam int PMAX = (1 << (PBW-1)) - 1;
  localparam int PMIN = -(1 << (PBW-1));

  logic                  clk = 1'b0;
  logic                  rstn = 1'b0;
  logic signed [DBW-1:0] DIN = '0;
  logic                  din_vld = 1'b0;
  logic signed [PBW-1:0] PSUM_IN = '0;
  logic signed [WBW-1:0] W_IN = '0;
  logic                  w_ld_in = 1'b0;
  logic                  w_swap_in = 1'b0;
  logic signed [DBW-1:0] DF_COL;
  logic                  dout_vld;
  logic signed [PBW-1:0] PSUM_OUT;
  logic signed [WBW-1:0] W_OUT;
  logic                  w_ld_out, w_swap_out, w_err, ovf;

  pe_ws_dbuf #(.DATA_IN_BW(DBW), .WEIGHT_BW(WBW), .PARTIAL_SUM_BW(PBW)) dut (
    .clk(clk), .rstn(rstn), .DIN(DIN), .din_vld(din_vld), .PSUM_IN(PSUM_IN),
    .W_IN(W_IN), .w_ld_in(w_ld_in), .w_swap_in(w_swap_in), .DF_COL(DF_COL),
    .dout_vld(dout_vld), .PSUM_OUT(PSUM_OUT), .W_OUT(W_OUT), .w_ld_out(w_ld_out),
    .w_swap_out(w_swap_out), .w_err(w_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int psum; int df; bit dvld; int wout; bit wld; bit wswap; bit werr; bit ovf;
    bit sp_psum_en; int sp_psum; bit sp_err_en; bit sp_err;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  // Reference model: two weight slots with presence flags, integer arithmetic.
  bit m_act_v = 0, m_sh_v = 0, m_err = 0, m_ovf = 0;
  int m_act = 0, m_sh = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  task automatic model_step(input bit r, input int din, input bit vld, input int pin,
                            input int win, input bit ld, input bit sw, output exp_t e);
    int s;
    e = '{default: 0};
    if (!r) begin
      m_act_v = 0; m_sh_v = 0; m_err = 0; m_ovf = 0; m_act = 0; m_sh = 0;
      return;
    end
    s = pin + ((vld && m_act_v) ? din * m_act : 0);
`ifdef PE_SAT_EN
    if (s > PMAX) begin s = PMAX; m_ovf = 1; end
    else if (s < PMIN) begin s = PMIN; m_ovf = 1; end
`else
    s = s & ((1 << PBW) - 1);
    if (s > PMAX) s = s - (1 << PBW);
`endif
    if (sw) begin
      if (m_sh_v) begin m_act = m_sh; m_act_v = 1; m_sh_v = 0; end
      else m_err = 1;
    end
    if (ld) begin m_sh = win; m_sh_v = 1; end
    e.psum = s; e.df = din; e.dvld = vld; e.wout = win; e.wld = ld; e.wswap = sw;
    e.werr = m_err; e.ovf = m_ovf;
  endtask

  task automatic drv(input bit r, input int din, input bit vld, input int pin, input int win,
                     input bit ld, input bit sw, input bit spe = 0, input int sp = 0,
                     input bit see = 0, input bit se = 0);
    exp_t e;
    @(negedge clk);
    rstn = r; DIN = din[DBW-1:0]; din_vld = vld; PSUM_IN = pin[PBW-1:0];
    W_IN = win[WBW-1:0]; w_ld_in = ld; w_swap_in = sw;
    model_step(r, din, vld, pin, win, ld, sw, e);
    e.sp_psum_en = spe; e.sp_psum = sp; e.sp_err_en = see; e.sp_err = se;
    exp_q.push_back(e);
  endtask

  // Monitor: pop one expectation per registered output update and compare.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("psum_out", int'(PSUM_OUT), e.psum);
      chk("df_col", int'(DF_COL), e.df);
      chk("dout_vld", int'(dout_vld), int'(e.dvld));
      chk("w_out", int'(W_OUT), e.wout);
      chk("w_ld_out", int'(w_ld_out), int'(e.wld));
      chk("w_swap_out", int'(w_swap_out), int'(e.wswap));
      chk("w_err", int'(w_err), int'(e.werr));
      chk("ovf", int'(ovf), int'(e.ovf));
      if (e.sp_psum_en) chk("spot_psum", int'(PSUM_OUT), e.sp_psum);
      if (e.sp_err_en) chk("spot_w_err", int'(w_err), int'(e.sp_err));
    end
  end

  initial begin
    int din, pin, sel;
    // reset with random inputs, then compute without any weight
    drv(0, int'($urandom_range(0, 255)) - 128, 1, 1234, 55, 1, 1, 1, 0);
    drv(0, int'($urandom_range(0, 255)) - 128, 1, -77, -3, 1, 0, 1, 0);
    drv(1, 5, 1, 7, 0, 0, 0, 1, 7);
    // load 3, swap, MAC
    drv(1, 0, 0, 0, 3, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 1);
    drv(1, -4, 1, 10, 0, 0, 0, 1, -2);
    // double buffer: shadow -7 while streaming with active 3
    drv(1, 2, 1, 0, -7, 1, 0, 1, 6);
    drv(1, 2, 1, 0, 0, 0, 1, 1, 6);
    drv(1, 2, 1, 0, 0, 0, 0, 1, -14);
    drv(1, 2, 1, 1, 0, 0, 0, 1, -13);
    // swap in EMPTY
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 1, 1, 4, 0, 0, 1, 1, 4, 1, 1);
    // ld&swap in SHADOW
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 2, 1, 0);
    drv(1, 0, 0, 0, 9, 1, 1, 0, 0, 1, 0);
    drv(1, 1, 1, 0, 0, 0, 0, 1, 2);
    drv(1, 1, 1, 0, 0, 0, 1, 1, 2);
    drv(1, 1, 1, 0, 0, 0, 0, 1, 9, 1, 0);
    // extremes
    drv(0, 0, 0, 0, 0, 0, 0);
    drv(1, 0, 0, 0, -128, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 1);
`ifdef PE_SAT_EN
    drv(1, -128, 1, PMAX, 0, 0, 0, 1, PMAX);
`else
    drv(1, -128, 1, PMAX, 0, 0, 0, 1, -262144 + 16383);
`endif
    // reset during load discards the shadow
    drv(0, 0, 0, 0, 5, 1, 0);
    drv(1, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    drv(1, 3, 1, 3, 0, 0, 0, 1, 3);
    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      din = int'($urandom_range(0, 255)) - 128;
      sel = int'($urandom_range(0, 3));
      pin = (sel == 0) ? PMAX : (sel == 1) ? PMIN : int'($urandom_range(0, (1 << PBW) - 1)) + PMIN;
      drv($urandom_range(0, 59) != 0, din, $urandom_range(0, 3) != 0, pin,
          int'($urandom_range(0, 255)) - 128, $urandom_range(0, 2) == 0, $urandom_range(0, 4) == 0);
    end
    @(negedge clk);
    w_ld_in = 1'b0; w_swap_in = 1'b0; din_vld = 1'b0;
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
